// File: rtl/soc_bus_pkg.sv
// Shared encodings and bus widths for the two-master native-bus arbiter.
package soc_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // State values double as the one-hot owner code seen on the owner port.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

endpackage

// File: rtl/soc_bus_arbiter_rr_arb2.sv
// Two-request round-robin pick: on a tie the master not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // last is 0 when m0 was served most recently, 1 when m1 was.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native bus; the grant is held until completion.
// Define SOC_BUS_TIMEOUT_EN to add a watchdog that completes stalled slave transactions.
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        owner,
  output logic              timeout_err
);

  state_t     state, next_state;
  logic       last, next_last;
  logic [1:0] grant;
  logic       cur_valid;
  logic       fire;

  rr_arb2 u_rr_arb2 (
    .req   ({m1_valid, m0_valid}),
    .last  (last),
    .grant (grant)
  );

  assign cur_valid = (state == G0) ? m0_valid :
                     (state == G1) ? m1_valid : 1'b0;

`ifdef SOC_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;
  logic             err_q;

  // The counter is held at zero while idle, so every grant starts counting from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)
        count <= '0;
      else if (!s_ready)
        count <= count + 1'b1;
      if (fire)
        err_q <= 1'b1;
    end
  end

  assign fire        = cur_valid && !s_ready && (count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;
`else
  logic unused_cfg;

  assign fire        = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      last  <= next_last;
    end
  end

  // An owner that drops valid early is aborted without counting as its turn.
  always_comb begin
    next_state = state;
    next_last  = last;
    case (state)
      IDLE: begin
        if (grant[0])
          next_state = G0;
        else if (grant[1])
          next_state = G1;
      end
      G0, G1: begin
        if (!cur_valid) begin
          next_state = IDLE;
        end else if (s_ready || fire) begin
          next_state = IDLE;
          next_last  = (state == G1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    case (state)
      G0: begin
        s_valid  = m0_valid;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready || fire;
        m0_rdata = fire ? TIMEOUT_RDATA : s_rdata;
      end
      G1: begin
        s_valid  = m1_valid;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready || fire;
        m1_rdata = fire ? TIMEOUT_RDATA : s_rdata;
      end
      default: ;
    endcase
  end

  assign owner = state;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Randomized and directed bench for soc_bus_arbiter against a transaction-level reference model.
// Build with SOC_BUS_TIMEOUT_EN defined to also exercise the watchdog.
module tb_soc_bus_arbiter;

  localparam int          TC  = 8;
  localparam logic [31:0] TRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  owner;
  logic        timeout_err;

  always #5 clk = ~clk;

  soc_bus_arbiter #(.TIMEOUT_CYCLES(TC), .TIMEOUT_RDATA(TRD)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .timeout_err(timeout_err)
  );

  int compareCount = 0;
  int failCount    = 0;

  // Reference model: which master holds the bus (0 none, 1 m0, 2 m1), who was served last.
  int          own;
  int          lastM;
  int          waitCycles;
  bit          expErr;
  logic        eSValid, eReady0, eReady1;
  logic [31:0] eSAddr, eSWdata, eRdata0, eRdata1;
  logic [3:0]  eSWstrb;
  logic [1:0]  eOwner;

  logic [1:0]  seenOwner;
  logic [1:0]  prevOwner;
  logic [1:0]  grantLog[$];

  function automatic void modelReset();
    own        = 0;
    lastM      = 1;
    waitCycles = 0;
    expErr     = 1'b0;
  endfunction

  function automatic bit ownerValid();
    return (own == 1) ? m0_valid : (own == 2) ? m1_valid : 1'b0;
  endfunction

  function automatic bit fireNow();
`ifdef SOC_BUS_TIMEOUT_EN
    return own != 0 && ownerValid() && !s_ready && waitCycles == TC - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void modelOutputs();
    bit fire;
    fire    = fireNow();
    eSValid = 1'b0; eSAddr = '0; eSWdata = '0; eSWstrb = '0;
    eReady0 = 1'b0; eRdata0 = '0; eReady1 = 1'b0; eRdata1 = '0;
    eOwner  = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
    if (own == 1) begin
      eSValid = m0_valid; eSAddr = m0_addr; eSWdata = m0_wdata; eSWstrb = m0_wstrb;
      eReady0 = s_ready | fire;
      eRdata0 = fire ? TRD : s_rdata;
    end else if (own == 2) begin
      eSValid = m1_valid; eSAddr = m1_addr; eSWdata = m1_wdata; eSWstrb = m1_wstrb;
      eReady1 = s_ready | fire;
      eRdata1 = fire ? TRD : s_rdata;
    end
  endfunction

  function automatic void modelStep();
    bit fire;
    fire = fireNow();
    if (own == 0) begin
      waitCycles = 0;
      if (m0_valid && m1_valid) own = (lastM == 0) ? 2 : 1;
      else if (m0_valid)        own = 1;
      else if (m1_valid)        own = 2;
    end else if (!ownerValid()) begin
      own = 0;
    end else if (s_ready || fire) begin
      if (fire) expErr = 1'b1;
      lastM = own - 1;
      own   = 0;
    end else begin
      waitCycles++;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Called at posedge+1: drive the slave side, check mid-cycle, then advance the model.
  task automatic applyStimulus(input logic sr, input logic [31:0] rd);
    s_ready = sr;
    s_rdata = rd;
    #3;
    modelOutputs();
    seenOwner = owner;
    if (owner != 2'b00 && owner != prevOwner) grantLog.push_back(owner);
    prevOwner = owner;
    checkOutput("owner",       owner,       eOwner);
    checkOutput("s_valid",     s_valid,     eSValid);
    checkOutput("s_addr",      s_addr,      eSAddr);
    checkOutput("s_wdata",     s_wdata,     eSWdata);
    checkOutput("s_wstrb",     s_wstrb,     eSWstrb);
    checkOutput("m0_ready",    m0_ready,    eReady0);
    checkOutput("m0_rdata",    m0_rdata,    eRdata0);
    checkOutput("m1_ready",    m1_ready,    eReady1);
    checkOutput("m1_rdata",    m1_rdata,    eRdata1);
    checkOutput("timeout_err", timeout_err, expErr);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    resetn   = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    s_ready  = 1'b0; s_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_owner",   owner,       2'b00);
    checkOutput("rst_s_valid", s_valid,     1'b0);
    checkOutput("rst_m0_rdy",  m0_ready,    1'b0);
    checkOutput("rst_m1_rdy",  m1_ready,    1'b0);
    checkOutput("rst_err",     timeout_err, 1'b0);
    resetn = 1'b1;
    modelReset();
    prevOwner = 2'b00;
  endtask

  // Masters hold a request until the model says it completed, then may re-request.
  task automatic masterCycles(input int n, input int reqPct, input int readyPct, input int dropPct);
    for (int i = 0; i < n; i++) begin
      if (!m0_valid && $urandom_range(99) < reqPct) begin
        m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end else if (m0_valid && $urandom_range(99) < dropPct) begin
        m0_valid = 1'b0;
      end
      if (!m1_valid && $urandom_range(99) < reqPct) begin
        m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end else if (m1_valid && $urandom_range(99) < dropPct) begin
        m1_valid = 1'b0;
      end
      applyStimulus($urandom_range(99) < readyPct, $urandom);
      if (eReady0) m0_valid = 1'b0;
      if (eReady1) m1_valid = 1'b0;
    end
  endtask

  initial begin
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    prevOwner = 2'b00;
    doReset();

    // Lone m0 read, slave answers on the second grant cycle.
    m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wdata = '0; m0_wstrb = 4'h0;
    applyStimulus(1'b0, 32'h0);
    checkOutput("t1_idle", seenOwner, 2'b00);
    applyStimulus(1'b0, 32'h0);
    checkOutput("t1_grant", seenOwner, 2'b01);
    applyStimulus(1'b1, 32'h1234_5678);
    m0_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);

    // Simultaneous requests after reset: m0 first, then m1 after one idle cycle.
    doReset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_0000; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_addr = 32'h0200_0000; m1_wdata = 32'h2222_0000; m1_wstrb = 4'h3;
    applyStimulus(1'b0, 32'h0);
    checkOutput("t2_own0", seenOwner, 2'b00);
    applyStimulus(1'b1, 32'hA5A5_0001);
    checkOutput("t2_own1", seenOwner, 2'b01);
    m0_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);
    checkOutput("t2_own2", seenOwner, 2'b00);
    applyStimulus(1'b1, 32'hA5A5_0002);
    checkOutput("t2_own3", seenOwner, 2'b10);
    m1_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);

    // Both masters requesting continuously must alternate.
    grantLog.delete();
    masterCycles(10, 100, 100, 0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t3_grant%0d", k), (grantLog.size() > k) ? grantLog[k] : 2'b11,
                  (k % 2 == 0) ? 2'b01 : 2'b10);
    m0_valid = 1'b0; m1_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);

    // Owner abort: m0 drops valid early, so its turn does not count and it wins the tie again.
    doReset();
    m0_valid = 1'b1; m1_valid = 1'b1;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("t6_g0", seenOwner, 2'b01);
    m0_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);
    m0_valid = 1'b1;
    applyStimulus(1'b0, 32'h0);
    checkOutput("t6_idle", seenOwner, 2'b00);
    applyStimulus(1'b1, 32'h0BAD_F00D);
    checkOutput("t6_regrant", seenOwner, 2'b01);
    m0_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h600D_0001);
    checkOutput("t6_m1", seenOwner, 2'b10);
    m1_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);

    // Asynchronous reset in the middle of a G0 transaction.
    m0_valid = 1'b1; m0_addr = 32'h0000_0040;
    applyStimulus(1'b0, 32'h0);
    s_ready = 1'b0;
    #3;
    checkOutput("t5_svalid_pre", s_valid, 1'b1);
    resetn  = 1'b0;
    s_ready = 1'b1;
    #1;
    checkOutput("t5_svalid", s_valid,  1'b0);
    checkOutput("t5_owner",  owner,    2'b00);
    checkOutput("t5_m0rdy",  m0_ready, 1'b0);
    @(posedge clk);
    #1;
    s_ready = 1'b0;
    resetn  = 1'b1;
    modelReset();
    prevOwner = 2'b00;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h7777_0000);
    checkOutput("t5_regrant", seenOwner, 2'b01);
    m0_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);

`ifdef SOC_BUS_TIMEOUT_EN
    // Stalled m1 write: the watchdog completes it on the eighth grant cycle.
    doReset();
    m1_valid = 1'b1; m1_addr = 32'h0200_0008; m1_wdata = 32'hCAFE_0008; m1_wstrb = 4'hF;
    applyStimulus(1'b0, 32'h0);
    for (int k = 0; k < TC; k++) applyStimulus(1'b0, $urandom);
    checkOutput("t4_err", timeout_err, 1'b1);
    m1_valid = 1'b0;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("t4_err_sticky", timeout_err, 1'b1);
`endif

    doReset();
    masterCycles(400, 40, 35, 3);
    masterCycles(200, 90, 60, 0);

    $display("== %0d vectors applied, %0d miscompares ==", compareCount, failCount);
    $finish;
  end

endmodule
